// File: rtl/spi_host_txn.sv
// spi_host_txn: SPI initiator that issues one 3-byte register transaction
// towards the PWM register-file peripheral. Each transaction sends a command
// byte {rw, addr[6:0]}, then a data MSB byte, then a data LSB byte. Every byte
// gets its own active-high ss pulse followed by an idle gap with ss low.
//
// Ports:
//   sys_clk  system clock, all logic on its rising edge
//   rst      asynchronous, active-high reset
//   start    request pulse, only looked at while idle
//   rw       1 = read, 0 = write (captured with start)
//   addr     7-bit register address (captured with start)
//   wdata    16-bit write data (captured with start, ignored for reads)
//   busy     high from the cycle after acceptance until done
//   done     one-cycle pulse at the end of the transaction
//   rdata    read result, only updated when a read finishes
//   ss       slave select, active-high, high only while a byte is framed
//   sclk     serial clock, idles low
//   mosi     serial data out, MSB first
//   miso     serial data in
//
// Byte timing: one CLK_DIV-cycle setup phase with sclk low and the MSB on
// mosi, then 16 half-periods of CLK_DIV cycles. The first half-period is low,
// so rising edges fall at the end of even half-periods and falling edges at
// the end of odd ones; ss drops together with the 8th falling edge, giving
// 17*CLK_DIV cycles of ss high per byte. GAP_CYCLES idle cycles follow.

module spi_host_txn #(
    parameter int CLK_DIV    = 5,
    parameter int GAP_CYCLES = 8
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        ss,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       half_cnt, half_cnt_n;
    logic [1:0]       byte_idx, byte_idx_n;
    logic [23:0]      frame, frame_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic [7:0]       rx_hi, rx_hi_n;
    logic [7:0]       rx_lo, rx_lo_n;
    logic             rw_q, rw_q_n;
    logic             busy_n, done_n, ss_n, sclk_n, mosi_n;
    logic [15:0]      rdata_n;

    // All state and all outputs are registered here so ss/sclk/mosi come
    // straight from flops and never glitch. Reset drops every line at once.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            half_cnt <= '0;
            byte_idx <= '0;
            frame    <= '0;
            rx_shift <= '0;
            rx_hi    <= '0;
            rx_lo    <= '0;
            rw_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            ss       <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            half_cnt <= half_cnt_n;
            byte_idx <= byte_idx_n;
            frame    <= frame_n;
            rx_shift <= rx_shift_n;
            rx_hi    <= rx_hi_n;
            rx_lo    <= rx_lo_n;
            rw_q     <= rw_q_n;
            busy     <= busy_n;
            done     <= done_n;
            rdata    <= rdata_n;
            ss       <= ss_n;
            sclk     <= sclk_n;
            mosi     <= mosi_n;
        end
    end

    // Next-state and next-output logic. The three tx bytes live in one 24-bit
    // register shifted left on every falling sclk edge, so bit 23 always holds
    // the bit due next. The shift on the 8th falling edge of a byte leaves the
    // next byte's MSB at bit 23 ready for its setup phase, while mosi itself
    // keeps the last bit through the gap.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        half_cnt_n = half_cnt;
        byte_idx_n = byte_idx;
        frame_n    = frame;
        rx_shift_n = rx_shift;
        rx_hi_n    = rx_hi;
        rx_lo_n    = rx_lo;
        rw_q_n     = rw_q;
        busy_n     = busy;
        done_n     = 1'b0;
        rdata_n    = rdata;
        ss_n       = ss;
        sclk_n     = sclk;
        mosi_n     = mosi;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = SETUP;
                    frame_n    = {rw, addr, (rw ? 16'h0000 : wdata)};
                    rw_q_n     = rw;
                    byte_idx_n = 2'd0;
                    cnt_n      = '0;
                    half_cnt_n = 4'd0;
                    busy_n     = 1'b1;
                    ss_n       = 1'b1;
                    sclk_n     = 1'b0;
                    mosi_n     = rw;
                end
            end

            SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_n    = SHIFT;
                    cnt_n      = '0;
                    half_cnt_n = 4'd0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_n      = '0;
                    half_cnt_n = half_cnt + 4'd1;
                    if (!half_cnt[0]) begin
                        // sclk rises here: sample the peripheral's data bit
                        sclk_n     = 1'b1;
                        rx_shift_n = {rx_shift[6:0], miso};
                    end else begin
                        sclk_n  = 1'b0;
                        frame_n = {frame[22:0], 1'b0};
                        if (half_cnt == 4'd15) begin
                            // 8th falling edge closes the byte
                            ss_n       = 1'b0;
                            state_n    = GAP;
                            half_cnt_n = 4'd0;
                            if (byte_idx == 2'd1) begin
                                rx_hi_n = rx_shift;
                            end
                            if (byte_idx == 2'd2) begin
                                rx_lo_n = rx_shift;
                            end
                        end else begin
                            mosi_n = frame[22];
                        end
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (byte_idx < 2'd2) begin
                        byte_idx_n = byte_idx + 2'd1;
                        state_n    = SETUP;
                        ss_n       = 1'b1;
                        mosi_n     = frame[23];
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        if (rw_q) begin
                            rdata_n = {rx_hi, rx_lo};
                        end
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            DONE: begin
                // start is deliberately ignored here; idle accepts it next cycle
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
